// File: rtl/bp_fe_packer_if.sv
// rtl/bp_fe_packer_if.sv - redirect, instruction-in and fetch-word-out handshakes of the fetch-stream packer
interface bp_fe_packer_if #(
  parameter int vaddr_width_p = 39
);
  logic                     redirect_v_i;
  logic [vaddr_width_p-1:0] redirect_pc_i;
  logic                     instr_v_i;
  logic [31:0]              instr_i;
  logic                     instr_ready_and_o;
  logic                     fetch_v_o;
  logic [vaddr_width_p-1:0] fetch_pc_o;
  logic [31:0]              fetch_data_o;
  logic                     fetch_straddle_o;
  logic                     fetch_yumi_i;
  logic                     idle_o;

  modport slave (
    input  redirect_v_i, redirect_pc_i, instr_v_i, instr_i, fetch_yumi_i,
    output instr_ready_and_o, fetch_v_o, fetch_pc_o, fetch_data_o, fetch_straddle_o, idle_o
  );

  modport master (
    output redirect_v_i, redirect_pc_i, instr_v_i, instr_i, fetch_yumi_i,
    input  instr_ready_and_o, fetch_v_o, fetch_pc_o, fetch_data_o, fetch_straddle_o, idle_o
  );
endinterface

// File: rtl/bp_fe_packer.sv
// rtl/bp_fe_packer.sv - packs a 16b/32b RV64 instruction stream into 32b-aligned fetch words
// Optional BP_FE_PACKER_FLUSH_EN adds flush_i, which pads out a trailing half-filled word.
module bp_fe_packer #(
  parameter int vaddr_width_p = 39
) (
  input  logic          clk_i,
  input  logic          reset_i,
`ifdef BP_FE_PACKER_FLUSH_EN
  input  logic          flush_i,
`endif
  bp_fe_packer_if.slave io
);
  typedef enum logic [1:0] {e_lo = 2'd0, e_hi = 2'd1, e_full = 2'd2} state_e;

  state_e                   state_q, state_d;
  logic [31:0]              acc_data_q, acc_data_d;
  logic                     acc_lo_v_q, acc_lo_v_d;
  logic                     acc_straddle_q, acc_straddle_d;
  logic [vaddr_width_p-1:0] acc_pc_q, acc_pc_d;
  logic [vaddr_width_p-1:0] base_q, base_d;
  logic                     carry_v_q, carry_v_d;
  logic [15:0]              carry_q, carry_d;
  logic                     out_v_q, out_v_d;
  logic [31:0]              out_data_q, out_data_d;
  logic [vaddr_width_p-1:0] out_pc_q, out_pc_d;
  logic                     out_straddle_q, out_straddle_d;

  logic                     ready, accept, is_c, transfer, flush_go;
  logic [vaddr_width_p-1:0] redir_base, redir_pc;

  assign is_c       = (io.instr_i[1:0] != 2'b11);
  assign accept     = io.instr_v_i & ready;
  assign transfer   = (state_q == e_full) & (~out_v_q | io.fetch_yumi_i);
  assign redir_base = io.redirect_pc_i & ~vaddr_width_p'(3);
  assign redir_pc   = io.redirect_pc_i & ~vaddr_width_p'(1);

`ifdef BP_FE_PACKER_FLUSH_EN
  // A same-cycle accept fills hi with real data, so padding only happens while the input is quiet.
  assign flush_go = flush_i & ~io.redirect_v_i & (state_q == e_hi) & acc_lo_v_q & ~carry_v_q & ~accept;
`else
  assign flush_go = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= e_lo;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (io.redirect_v_i) begin
      state_d = io.redirect_pc_i[1] ? e_hi : e_lo;
    end else if (transfer) begin
      state_d = carry_v_q ? e_hi : e_lo;
    end else if (accept) begin
      case (state_q)
        e_lo:    state_d = is_c ? e_hi : e_full;
        e_hi:    state_d = e_full;
        default: state_d = state_q;
      endcase
    end else if (flush_go) begin
      state_d = e_full;
    end
  end

  always_comb begin
    ready     = ~reset_i & ~io.redirect_v_i & ~carry_v_q & (state_q != e_full);
    io.idle_o = ((state_q == e_lo) & ~carry_v_q & ~out_v_q) |
                ((state_q == e_hi) & ~acc_lo_v_q & ~out_v_q);
  end

  assign io.instr_ready_and_o = ready;
  assign io.fetch_v_o         = out_v_q;
  assign io.fetch_pc_o        = out_pc_q;
  assign io.fetch_data_o      = out_data_q;
  assign io.fetch_straddle_o  = out_straddle_q;

  always_comb begin
    acc_data_d     = acc_data_q;
    acc_lo_v_d     = acc_lo_v_q;
    acc_straddle_d = acc_straddle_q;
    acc_pc_d       = acc_pc_q;
    base_d         = base_q;
    carry_v_d      = carry_v_q;
    carry_d        = carry_q;
    out_v_d        = out_v_q;
    out_data_d     = out_data_q;
    out_pc_d       = out_pc_q;
    out_straddle_d = out_straddle_q;
    if (io.redirect_v_i) begin
      out_v_d        = 1'b0;
      carry_v_d      = 1'b0;
      acc_data_d     = 32'h0;
      acc_lo_v_d     = 1'b0;
      acc_straddle_d = 1'b0;
      base_d         = redir_base;
      acc_pc_d       = redir_pc;
    end else if (transfer) begin
      out_v_d        = 1'b1;
      out_data_d     = acc_data_q;
      out_pc_d       = acc_pc_q;
      out_straddle_d = acc_straddle_q;
      base_d         = base_q + vaddr_width_p'(4);
      acc_pc_d       = base_q + vaddr_width_p'(4);
      // The upper half of a split 32b instruction opens the next word.
      acc_data_d     = {16'h0, carry_v_q ? carry_q : 16'h0};
      acc_lo_v_d     = carry_v_q;
      acc_straddle_d = 1'b0;
      carry_v_d      = 1'b0;
    end else begin
      if (io.fetch_yumi_i) out_v_d = 1'b0;
      if (accept) begin
        if (state_q == e_lo) begin
          acc_data_d[15:0] = io.instr_i[15:0];
          acc_lo_v_d       = 1'b1;
          if (!is_c) acc_data_d[31:16] = io.instr_i[31:16];
        end else begin
          acc_data_d[31:16] = io.instr_i[15:0];
          if (!is_c) begin
            carry_d        = io.instr_i[31:16];
            carry_v_d      = 1'b1;
            acc_straddle_d = 1'b1;
          end
        end
      end else if (flush_go) begin
        acc_data_d[31:16] = 16'h0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_data_q     <= 32'h0;
      acc_lo_v_q     <= 1'b0;
      acc_straddle_q <= 1'b0;
      acc_pc_q       <= '0;
      base_q         <= '0;
      carry_v_q      <= 1'b0;
      carry_q        <= 16'h0;
      out_v_q        <= 1'b0;
      out_data_q     <= 32'h0;
      out_pc_q       <= '0;
      out_straddle_q <= 1'b0;
    end else begin
      acc_data_q     <= acc_data_d;
      acc_lo_v_q     <= acc_lo_v_d;
      acc_straddle_q <= acc_straddle_d;
      acc_pc_q       <= acc_pc_d;
      base_q         <= base_d;
      carry_v_q      <= carry_v_d;
      carry_q        <= carry_d;
      out_v_q        <= out_v_d;
      out_data_q     <= out_data_d;
      out_pc_q       <= out_pc_d;
      out_straddle_q <= out_straddle_d;
    end
  end
endmodule
